result_stream_framer: RTL and testbench
=======================================

# result_stream_framer

Serialises one decode result into the 32-bit output stream that the decoder's output FIFO carries off-chip or to the bench. Per decode it emits:
- a header word with cycle and iteration counts;
- one word per correction entry from the peeling engine;
- a count word;
- the 0xFFFFFFFF terminator.

It sits between the controller/peeling logic and the output FIFO. It is the transmitter for the stream reader that takes the header as message 0 and ends a frame on 0xFFFFFFFF.

## Interface
Parameters:
- X_BIT_WIDTH, default 4: width of the correction x coordinate, ≤ 8.
- Z_BIT_WIDTH, default 3: width of the z coordinate, ≤ 8.
- U_BIT_WIDTH, default 4: width of the u (round/context) coordinate, ≤ 8.

Ports:
- clk  in  1  clock; all logic rises on posedge.
- reset  in  1  synchronous, active-high.
- start_valid  in  1  a decode has finished and its result is ready to frame.
- start_ready  out  1  framer is idle.
- start_cycles  in  32  clustering cycle count.
- start_iterations  in  32  iteration count.
- start_empty  in  1  the frame has no correction entries.
- corr_valid  in  1  correction entry present.
- corr_ready  out  1  entry accepted this cycle.
- corr_x / corr_z / corr_u  in  X/Z/U_BIT_WIDTH  coordinates of the entry.
- corr_last  in  1  this entry is the last one of the frame.
- output_data  out  32  stream word.
- output_valid  out  1  output_data is valid.
- output_ready  in  1  downstream accepts the word.

## Operation
- Word formats:
  - Header: [31:24]=0, [23:16]=sat8(iterations), [15:0]=sat16(cycles). Saturation means any value above the max maps to 0xFF / 0xFFFF.
  - Entry: [31:24]=0, [23:16]=u, [15:8]=x, [7:0]=z. Each coordinate is zero-extended.
  - Count: [31:24]=0xFE, [23:16]=0, [15:0]=number of entries, saturating at 0xFFFF.
  - Terminator: 0xFFFFFFFF.
  - No header, entry or count word can equal the terminator.
- FSM states and transitions:
  - IDLE → HEADER on start handshake. The handshake latches the saturated counts and start_empty, and clears the entry counter.
  - HEADER → BODY when the header word is accepted. If start_empty is latched, go to COUNT instead.
  - BODY → COUNT when the entry with corr_last=1 is handed to the output register.
  - COUNT → TERM when the count word is accepted.
  - TERM → IDLE when the terminator is accepted.
- start_ready = (state==IDLE). Frames never overlap.
- corr_ready = (state==BODY) && (!output_valid || output_ready). Entries are never dropped or duplicated.
- The entry counter increments on every corr handshake and saturates at 0xFFFF.
- corr_valid outside BODY is ignored: corr_ready=0.
- Reset at any point, including mid-frame:
  - state=IDLE, output_valid=0, output_data=0;
  - start_ready=1, corr_ready=0, counters=0;
  - a partial frame is abandoned with no terminator.

## Timing
- Single-stage registered output: output_data and output_valid are flops.
- Entering each emitting state loads the next word into the output register in that cycle, provided the register is empty or being drained that cycle.
- The header is visible (output_valid=1) on the cycle after the start handshake.
- Throughput is 1 word/cycle when output_ready=1 and corr_valid=1.
- Minimum frame length:
  - non-empty: 3 + N words, header appearing 1 cycle after start;
  - empty: exactly 3 words.
- Valid/data hold: while output_valid=1 and output_ready=0, output_data is stable and output_valid stays high.
- output_valid may fall only after a handshake.
- A new start is accepted the cycle after the terminator handshake, when start_ready rises.

## Structure
- Shared package result_stream_pkg holds:
  - the state enum (IDLE, HEADER, BODY, COUNT, TERM);
  - TERMINATOR_WORD=32'hFFFFFFFF and COUNT_TAG=8'hFE;
  - functions sat16 and sat8.
- One sub-module, stream_out_reg: a 32-bit valid/ready output register exposing a can_load flag. The FSM and word mux live in result_stream_framer.

## Test plan
- Basic frame: start with cycles=0x1234, iterations=5, then entries (u=2,x=3,z=1) and (u=0,x=7,z=4, last), output_ready=1. Expected stream: 0x00051234, 0x00020301, 0x00000704, 0xFE000002, 0xFFFFFFFF.
- Empty frame: start_empty=1, cycles=7, iterations=1. Expected stream: 0x00010007, 0xFE000000, 0xFFFFFFFF. corr_ready never asserts.
- Saturation: cycles=0x0001_0000 and iterations=300 give header 0x00FFFFFF. After 70000 entries the count word is 0xFE00FFFF.
- Backpressure: toggle output_ready pseudo-randomly (≈50%) over a 20-entry frame.
  - Every word is held stable until its handshake.
  - Stream order matches the input order.
  - No word is lost or duplicated.
- Start while busy: assert start_valid throughout a frame. start_ready=0 until the cycle after the terminator handshake; the second header then follows one cycle later.
- Reset mid-BODY after 2 entries. On the next cycle: output_valid=0, start_ready=1, corr_ready=0. A fresh frame then starts with its header and counts entries from 0.

Source files
------------

// File: rtl/result_stream_pkg.sv
// ============================================================================
// Module      : result_stream_pkg
// Description : Shared types, constants and saturation helpers for the
//               decode-result stream framer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package result_stream_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HEADER = 3'd1,
    BODY   = 3'd2,
    COUNT  = 3'd3,
    TERM   = 3'd4
  } state_t;

  localparam logic [31:0] TERMINATOR_WORD = 32'hFFFF_FFFF;
  localparam logic [7:0]  COUNT_TAG       = 8'hFE;

  function automatic logic [15:0] sat16(input logic [31:0] v);
    return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
  endfunction

  function automatic logic [7:0] sat8(input logic [31:0] v);
    return (v > 32'h0000_00FF) ? 8'hFF : v[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/stream_out_reg.sv
// ============================================================================
// Module      : stream_out_reg
// Description : Single-stage 32-bit valid/ready output register with a
//               can_load flag (empty, or being drained this cycle).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_out_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic        i_ready,
  output logic [31:0] o_data,
  output logic        o_valid,
  output logic        o_can_load
);

  logic [31:0] r_data;
  logic        r_valid;

  assign o_data     = r_data;
  assign o_valid    = r_valid;
  assign o_can_load = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= 32'h0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/result_stream_framer.sv
// ============================================================================
// Module      : result_stream_framer
// Description : Frames one decode result as header, entries, count and
//               0xFFFFFFFF terminator onto a 32-bit valid/ready stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_stream_framer
  import result_stream_pkg::*;
#(
  parameter int X_BIT_WIDTH = 4,
  parameter int Z_BIT_WIDTH = 3,
  parameter int U_BIT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [31:0]            start_cycles,
  input  logic [31:0]            start_iterations,
  input  logic                   start_empty,
  input  logic                   corr_valid,
  output logic                   corr_ready,
  input  logic [X_BIT_WIDTH-1:0] corr_x,
  input  logic [Z_BIT_WIDTH-1:0] corr_z,
  input  logic [U_BIT_WIDTH-1:0] corr_u,
  input  logic                   corr_last,
  output logic [31:0]            output_data,
  output logic                   output_valid,
  input  logic                   output_ready
);

  state_t      r_state;
  logic        r_empty;
  logic        r_word_loaded;
  logic [15:0] r_count;

  logic        w_can_load;
  logic        w_load;
  logic [31:0] w_load_data;
  logic        w_start_hs;
  logic        w_corr_hs;
  logic        w_out_hs;
  logic [31:0] w_header_word;
  logic [31:0] w_entry_word;
  logic [31:0] w_count_word;

  assign start_ready = (r_state == IDLE);
  assign corr_ready  = (r_state == BODY) && w_can_load;
  assign w_start_hs  = start_valid && start_ready;
  assign w_corr_hs   = corr_valid && corr_ready;
  assign w_out_hs    = output_valid && output_ready;

  // Every word with [31:24] of 0x00 or 0xFE can never alias the terminator.
  assign w_header_word = {8'h00, sat8(start_iterations), sat16(start_cycles)};
  assign w_entry_word  = {8'h00, 8'(corr_u), 8'(corr_x), 8'(corr_z)};
  assign w_count_word  = {COUNT_TAG, 8'h00, r_count};

  always_comb begin
    w_load      = 1'b0;
    w_load_data = 32'h0;
    case (r_state)
      IDLE: begin
        if (w_start_hs) begin
          w_load      = 1'b1;
          w_load_data = w_header_word;
        end
      end
      HEADER: begin
        if (w_out_hs && r_empty) begin
          w_load      = 1'b1;
          w_load_data = w_count_word;
        end
      end
      BODY: begin
        if (w_corr_hs) begin
          w_load      = 1'b1;
          w_load_data = w_entry_word;
        end
      end
      COUNT: begin
        if (!r_word_loaded && w_can_load) begin
          w_load      = 1'b1;
          w_load_data = w_count_word;
        end else if (r_word_loaded && w_out_hs) begin
          w_load      = 1'b1;
          w_load_data = TERMINATOR_WORD;
        end
      end
      default: begin
        w_load      = 1'b0;
        w_load_data = 32'h0;
      end
    endcase
  end

  // r_word_loaded tracks whether the count word already sits in the output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_empty       <= 1'b0;
      r_word_loaded <= 1'b0;
      r_count       <= 16'h0;
    end else begin
      if (w_corr_hs && (r_count != 16'hFFFF)) begin
        r_count <= r_count + 16'd1;
      end
      case (r_state)
        IDLE: begin
          if (w_start_hs) begin
            r_state       <= HEADER;
            r_empty       <= start_empty;
            r_count       <= 16'h0;
            r_word_loaded <= 1'b0;
          end
        end
        HEADER: begin
          if (w_out_hs) begin
            r_state       <= r_empty ? COUNT : BODY;
            r_word_loaded <= r_empty;
          end
        end
        BODY: begin
          if (w_corr_hs && corr_last) begin
            r_state       <= COUNT;
            r_word_loaded <= 1'b0;
          end
        end
        COUNT: begin
          if (!r_word_loaded && w_can_load) begin
            r_word_loaded <= 1'b1;
          end else if (r_word_loaded && w_out_hs) begin
            r_state <= TERM;
          end
        end
        TERM: begin
          if (w_out_hs) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  stream_out_reg u_out_reg (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_data     (w_load_data),
    .i_ready    (output_ready),
    .o_data     (output_data),
    .o_valid    (output_valid),
    .o_can_load (w_can_load)
  );

endmodule

`default_nettype wire

// File: tb/tb_result_stream_framer.sv
// ============================================================================
// Module      : tb_result_stream_framer
// Description : Directed self-checking bench for result_stream_framer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_stream_framer;

  localparam logic [31:0] TERM_W = 32'hFFFF_FFFF;

  logic        clk;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] start_cycles;
  logic [31:0] start_iterations;
  logic        start_empty;
  logic        corr_valid;
  logic        corr_ready;
  logic [3:0]  corr_x;
  logic [2:0]  corr_z;
  logic [3:0]  corr_u;
  logic        corr_last;
  logic [31:0] output_data;
  logic        output_valid;
  logic        output_ready;

  int errors = 0;
  int checks = 0;
  int term_cnt = 0;
  logic [31:0] out_q[$];
  int tu[32];
  int tx[32];
  int tz[32];

  result_stream_framer #(
    .X_BIT_WIDTH(4), .Z_BIT_WIDTH(3), .U_BIT_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_cycles(start_cycles), .start_iterations(start_iterations),
    .start_empty(start_empty),
    .corr_valid(corr_valid), .corr_ready(corr_ready),
    .corr_x(corr_x), .corr_z(corr_z), .corr_u(corr_u), .corr_last(corr_last),
    .output_data(output_data), .output_valid(output_valid),
    .output_ready(output_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accepted output words; inputs change just after posedge, so negedge sees the upcoming handshake.
  always @(negedge clk) begin
    if (!reset && output_valid && output_ready) begin
      out_q.push_back(output_data);
      if (output_data == TERM_W) term_cnt++;
    end
  end

  task automatic start_frame(input logic [31:0] cyc, input logic [31:0] it, input logic emp);
    logic ok;
    int c;
    ok = 1'b0;
    c = 0;
    start_valid = 1'b1; start_cycles = cyc; start_iterations = it; start_empty = emp;
    while (!ok && c < 50) begin
      @(negedge clk); ok = start_ready;
      @(posedge clk); #1; c++;
    end
    start_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL start_handshake: start_ready=0 required 1 within 50 cycles"); end
  endtask

  task automatic drive_entries(input int n, input int abort_after, input int budget);
    int i;
    int c;
    i = 0; c = 0;
    while (i < n && i != abort_after && c < budget) begin
      corr_valid = 1'b1;
      corr_u = 4'(tu[i % 32]); corr_x = 4'(tx[i % 32]); corr_z = 3'(tz[i % 32]);
      corr_last = (i == n - 1);
      @(negedge clk); if (corr_ready) i++;
      @(posedge clk); #1; c++;
    end
    corr_valid = 1'b0; corr_last = 1'b0;
    checks++;
    if (i < n && i != abort_after) begin
      errors++; $display("FAIL entry_feed: accepted=%0d required=%0d", i, n);
    end
  endtask

  task automatic wait_term(input int target, input int budget);
    int c;
    c = 0;
    while (term_cnt < target && c < budget) begin
      @(posedge clk); #1; c++;
    end
    checks++;
    if (term_cnt < target) begin errors++; $display("FAIL wait_term: terminators=%0d required=%0d", term_cnt, target); end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < 32; i++) begin
      tu[i] = i % 16; tx[i] = (i * 5 + 1) % 16; tz[i] = (i * 3) % 8;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got=%b want=0", output_valid); end
    checks++; if (output_data !== 32'h0) begin errors++; $display("FAIL reset_data: got=%h want=00000000", output_data); end
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready: got=%b want=1", start_ready); end
    checks++; if (corr_ready !== 1'b0) begin errors++; $display("FAIL reset_corr_ready: got=%b want=0", corr_ready); end
    @(posedge clk); #1; reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] exp_w[5];
    exp_w = '{32'h00051234, 32'h00020301, 32'h00000704, 32'hFE000002, 32'hFFFFFFFF};
    tu[0] = 2; tx[0] = 3; tz[0] = 1;
    tu[1] = 0; tx[1] = 7; tz[1] = 4;
    out_q.delete();
    start_frame(32'h1234, 32'd5, 1'b0);
    @(negedge clk);
    checks++;
    if (output_valid !== 1'b1 || output_data !== 32'h00051234) begin
      errors++; $display("FAIL basic_header_latency: valid=%b data=%h want 1/00051234", output_valid, output_data);
    end
    @(posedge clk); #1;
    drive_entries(2, -1, 50);
    wait_term(term_cnt + 1, 50);
    checks++;
    if (out_q.size() != 5) begin errors++; $display("FAIL basic_len: got=%0d want=5", out_q.size()); end
    for (int i = 0; i < 5 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_w[i]) begin errors++; $display("FAIL basic_word%0d: got=%h want=%h", i, out_q[i], exp_w[i]); end
    end
  endtask

  task automatic test_empty();
    logic [31:0] exp_w[3];
    logic seen_cr;
    int t0;
    exp_w = '{32'h00010007, 32'hFE000000, 32'hFFFFFFFF};
    out_q.delete();
    t0 = term_cnt;
    seen_cr = 1'b0;
    corr_valid = 1'b1;
    start_frame(32'd7, 32'd1, 1'b1);
    corr_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (output_valid !== 1'b1 || output_data !== 32'h00010007) begin
      errors++; $display("FAIL empty_header_latency: valid=%b data=%h want 1/00010007", output_valid, output_data);
    end
    for (int c = 0; c < 20 && term_cnt == t0; c++) begin
      seen_cr |= corr_ready;
      @(negedge clk);
    end
    corr_valid = 1'b0;
    checks++; if (seen_cr !== 1'b0) begin errors++; $display("FAIL empty_corr_ready: got=1 want=0"); end
    @(posedge clk); #1;
    checks++;
    if (out_q.size() != 3) begin errors++; $display("FAIL empty_len: got=%0d want=3", out_q.size()); end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_w[i]) begin errors++; $display("FAIL empty_word%0d: got=%h want=%h", i, out_q[i], exp_w[i]); end
    end
  endtask

  task automatic test_saturation();
    fill_pattern();
    out_q.delete();
    start_frame(32'h0001_0000, 32'd300, 1'b0);
    drive_entries(65540, -1, 70000);
    wait_term(term_cnt + 1, 50);
    checks++;
    if (out_q.size() != 65543) begin errors++; $display("FAIL sat_len: got=%0d want=65543", out_q.size()); end
    checks++;
    if (out_q.size() < 1 || out_q[0] !== 32'h00FFFFFF) begin errors++; $display("FAIL sat_header: got=%h want=00FFFFFF", (out_q.size() > 0) ? out_q[0] : 32'hx); end
    checks++;
    if (out_q.size() < 2 || out_q[out_q.size()-2] !== 32'hFE00FFFF) begin
      errors++; $display("FAIL sat_count: got=%h want=FE00FFFF", (out_q.size() > 1) ? out_q[out_q.size()-2] : 32'hx);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w;
    logic pv, pr, done;
    logic [31:0] pd;
    fill_pattern();
    out_q.delete();
    start_frame(32'h00AB, 32'd3, 1'b0);
    pv = 1'b0; pr = 1'b1; pd = 32'h0; done = 1'b0;
    fork
      drive_entries(20, -1, 400);
      begin
        for (int c = 0; c < 600 && !done; c++) begin
          @(negedge clk);
          if (pv && !pr) begin
            checks++;
            if (output_valid !== 1'b1 || output_data !== pd) begin
              errors++; $display("FAIL bp_hold: valid=%b data=%h want 1/%h", output_valid, output_data, pd);
            end
          end
          pv = output_valid; pr = output_ready; pd = output_data;
          if (output_valid && output_ready && output_data == TERM_W) done = 1'b1;
          @(posedge clk); #1;
          if (!done) output_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    output_ready = 1'b1;
    checks++; if (!done) begin errors++; $display("FAIL bp_done: terminator not seen, want seen"); end
    checks++;
    if (out_q.size() != 23) begin errors++; $display("FAIL bp_len: got=%0d want=23", out_q.size()); end
    for (int i = 0; i < 23 && i < out_q.size(); i++) begin
      if (i == 0) exp_w = 32'h000300AB;
      else if (i <= 20) exp_w = {8'h00, 8'(tu[i-1]), 8'(tx[i-1]), 8'(tz[i-1])};
      else if (i == 21) exp_w = 32'hFE000014;
      else exp_w = TERM_W;
      checks++;
      if (out_q[i] !== exp_w) begin errors++; $display("FAIL bp_word%0d: got=%h want=%h", i, out_q[i], exp_w); end
    end
  endtask

  task automatic test_back_to_back();
    logic found;
    int t0;
    t0 = term_cnt;
    found = 1'b0;
    start_valid = 1'b1; start_cycles = 32'd9; start_iterations = 32'd2; start_empty = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      checks++;
      if (start_ready !== 1'b0) begin errors++; $display("FAIL busy_start_ready: got=%b want=0", start_ready); end
      if (output_valid && output_ready && output_data == TERM_W) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL busy_term: terminator not seen, want seen"); end
    @(negedge clk);
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL busy_ready_rise: got=%b want=1", start_ready); end
    @(negedge clk);
    checks++;
    if (output_valid !== 1'b1 || output_data !== 32'h00020009) begin
      errors++; $display("FAIL busy_second_header: valid=%b data=%h want 1/00020009", output_valid, output_data);
    end
    @(posedge clk); #1;
    start_valid = 1'b0;
    wait_term(t0 + 2, 50);
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] exp_w[4];
    exp_w = '{32'h00040003, 32'h00010203, 32'hFE000001, 32'hFFFFFFFF};
    fill_pattern();
    start_frame(32'd50, 32'd6, 1'b0);
    drive_entries(5, 2, 50);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    corr_valid = 1'b1;
    @(negedge clk);
    checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got=%b want=0", output_valid); end
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL midrst_start_ready: got=%b want=1", start_ready); end
    checks++; if (corr_ready !== 1'b0) begin errors++; $display("FAIL midrst_corr_ready: got=%b want=0", corr_ready); end
    @(posedge clk); #1;
    corr_valid = 1'b0;
    out_q.delete();
    tu[0] = 1; tx[0] = 2; tz[0] = 3;
    start_frame(32'd3, 32'd4, 1'b0);
    drive_entries(1, -1, 50);
    wait_term(term_cnt + 1, 50);
    checks++;
    if (out_q.size() != 4) begin errors++; $display("FAIL midrst_len: got=%0d want=4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== exp_w[i]) begin errors++; $display("FAIL midrst_word%0d: got=%h want=%h", i, out_q[i], exp_w[i]); end
    end
  endtask

  initial begin
    reset = 1'b1; start_valid = 1'b0; start_cycles = 32'h0; start_iterations = 32'h0;
    start_empty = 1'b0; corr_valid = 1'b0; corr_x = 4'h0; corr_z = 3'h0; corr_u = 4'h0;
    corr_last = 1'b0; output_ready = 1'b1;
    test_reset();
    test_basic();
    test_empty();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
